program_counter: RTL and testbench

- Holds the 64-bit program counter for the ARM-style CPU fetch stage and computes the next PC every clock.
- Next PC is one of: PC+4, PC-relative conditional branch (CBZ / B.LT), PC-relative unconditional branch (B/BL), or branch-to-register (BR).
- Also outputs PC+4 so the link register can be written during BL.
- Built from a 64-bit state register (64 D flip-flops), a dedicated PC+4 incrementer, and a 64-bit ripple/lookahead adder for branch targets.

---
 rtl/program_counter.sv | 81 ++++++++
 tb/tb_program_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// Holds the 64-bit program counter for the fetch stage. Every clock it
// advances to one of the following:
//   - PC + 4 (sequential)
//   - PC + (offset << 2) (conditional CBZ / B.LT, or unconditional B / BL)
//   - Rd (BR)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset; clears currPC to 0
//   condAddr19  signed word offset for CBZ / B.LT
//   brAddr26    signed word offset for B / BL
//   uncondBr    1 = unconditional branch (uses brAddr26), 0 = uses condAddr19
//   branch      current instruction is a conditional branch
//   flagZero    zero condition used by CBZ
//   flagNeg     negative / less-than condition used by B.LT
//   opcode      opcode MSB: 1 = CBZ, 0 = B.LT
//   branchReg   BR: next PC = Rd (overrides every other select)
//   Rd          register value for BR
//   currPC      registered program counter
//   pc_plus4    currPC + 4, combinational (link value for BL)
// ---------------------------------------------------------------------------
module program_counter #(
    parameter int unsigned COND_ADDR_SIZE = 19,
    parameter int unsigned BR_ADDR_SIZE   = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COND_ADDR_SIZE-1:0] condAddr19,
    input  logic [BR_ADDR_SIZE-1:0]   brAddr26,
    input  logic                      uncondBr,
    input  logic                      branch,
    input  logic                      flagZero,
    input  logic                      flagNeg,
    input  logic                      opcode,
    input  logic                      branchReg,
    input  logic [63:0]               Rd,
    output logic [63:0]               currPC,
    output logic [63:0]               pc_plus4
);

    logic [63:0] condOff;
    logic [63:0] brOff;
    logic [63:0] off;
    logic [63:0] target;
    logic        cbzTaken;
    logic        ltTaken;
    logic        take;
    logic [63:0] seqPC;
    logic [63:0] nextPC;

    // Sign-extend both offset fields to the full datapath width.
    assign condOff = {{(64 - COND_ADDR_SIZE){condAddr19[COND_ADDR_SIZE-1]}}, condAddr19};
    assign brOff   = {{(64 - BR_ADDR_SIZE){brAddr26[BR_ADDR_SIZE-1]}}, brAddr26};

    always_comb begin
        off      = uncondBr ? brOff : condOff;
        // Word offset -> byte offset; sums wrap mod 2^64, carry discarded.
        target   = currPC + {off[61:0], 2'b00};
        pc_plus4 = currPC + 64'd4;

        // opcode selects which flag matters, so the two are exclusive.
        cbzTaken = branch & flagZero & opcode;
        ltTaken  = branch & flagNeg & ~opcode;
        take     = uncondBr | cbzTaken | ltTaken;

        seqPC    = take ? target : pc_plus4;
        nextPC   = branchReg ? Rd : seqPC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            currPC <= 64'h0;
        end else begin
            currPC <= nextPC;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//
// Directed bench for program_counter. Each step drives the control inputs,
// pushes the expected next PC onto a scoreboard queue, and after the next
// rising edge pops it and compares against currPC and pc_plus4.
// ---------------------------------------------------------------------------
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic [18:0] condAddr19;
    logic [25:0] brAddr26;
    logic        uncondBr;
    logic        branch;
    logic        flagZero;
    logic        flagNeg;
    logic        opcode;
    logic        branchReg;
    logic [63:0] Rd;
    logic [63:0] currPC;
    logic [63:0] pc_plus4;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    logic [63:0] expQ[$];
    logic [63:0] modelPc;

    program_counter #(
        .COND_ADDR_SIZE(19),
        .BR_ADDR_SIZE  (26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .condAddr19(condAddr19),
        .brAddr26  (brAddr26),
        .uncondBr  (uncondBr),
        .branch    (branch),
        .flagZero  (flagZero),
        .flagNeg   (flagNeg),
        .opcode    (opcode),
        .branchReg (branchReg),
        .Rd        (Rd),
        .currPC    (currPC),
        .pc_plus4  (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearCtrl();
        condAddr19 = '0;
        brAddr26   = '0;
        uncondBr   = 1'b0;
        branch     = 1'b0;
        flagZero   = 1'b0;
        flagNeg    = 1'b0;
        opcode     = 1'b0;
        branchReg  = 1'b0;
        Rd         = '0;
    endtask

    // Inputs already driven; push expectation, clock once, pop and compare.
    task automatic step(input string tag, input logic [63:0] expNext);
        logic [63:0] exp;
        expQ.push_back(expNext);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            check({tag, "_queue_empty"}, currPC, ~currPC);
        end else begin
            exp = expQ.pop_front();
            check(tag, currPC, exp);
            check({tag, "_plus4"}, pc_plus4, exp + 64'd4);
            modelPc = exp;
        end
    endtask

    initial begin
        rst = 1'b1;
        clearCtrl();
        modelPc = 64'h0;

        // Asynchronous reset, no clock edge needed.
        #1 rst = 1'b0;
        #2;
        check("reset_pc", currPC, 64'h0);
        check("reset_plus4", pc_plus4, 64'h4);
        @(posedge clk);
        #2 rst = 1'b1;

        // 21 sequential cycles -> 84.
        for (int i = 0; i < 21; i++) begin
            step("seq", modelPc + 64'd4);
        end
        check("seq_after21", currPC, 64'd84);

        // CBZ taken.
        branch = 1'b1; flagZero = 1'b1; opcode = 1'b1; condAddr19 = 19'd19;
        step("cbz_taken", modelPc + 64'd76);
        // Same with opcode = 0 -> B.LT, flagNeg low: not taken.
        opcode = 1'b0;
        step("cbz_as_blt_not_taken", modelPc + 64'd4);

        // B.LT taken.
        clearCtrl();
        branch = 1'b1; flagNeg = 1'b1; opcode = 1'b0; condAddr19 = 19'd5;
        step("blt_taken", modelPc + 64'd20);
        opcode = 1'b1;
        step("blt_as_cbz_not_taken", modelPc + 64'd4);

        // Unconditional branch, flags irrelevant.
        clearCtrl();
        uncondBr = 1'b1; brAddr26 = 26'd50; flagNeg = 1'b1; opcode = 1'b1; flagZero = 1'b0;
        step("uncond", modelPc + 64'd200);

        // Negative conditional offset (-1 word).
        clearCtrl();
        branch = 1'b1; flagZero = 1'b1; opcode = 1'b1; condAddr19 = 19'h7FFFF;
        step("cbz_neg", modelPc - 64'd4);

        // branch = 0: flags ignored.
        clearCtrl();
        flagZero = 1'b1; flagNeg = 1'b1; opcode = 1'b1; condAddr19 = 19'd100;
        step("no_branch_flags", modelPc + 64'd4);

        // BR overrides a taken CBZ.
        clearCtrl();
        branchReg = 1'b1; Rd = 64'd12;
        branch = 1'b1; flagZero = 1'b1; opcode = 1'b1; condAddr19 = 19'd19;
        step("br_override", 64'd12);

        // Wrap of pc_plus4 at the top of the address space.
        clearCtrl();
        branchReg = 1'b1; Rd = 64'hFFFF_FFFF_FFFF_FFFC;
        step("br_top", 64'hFFFF_FFFF_FFFF_FFFC);
        clearCtrl();
        step("wrap_seq", 64'h0);

        // Most negative 26-bit offset from PC 0 wraps below zero.
        uncondBr = 1'b1; brAddr26 = 26'h2000000;
        step("uncond_min", 64'hFFFF_FFFF_F800_0000);

        // Async reset mid-run from PC 0x100.
        clearCtrl();
        branchReg = 1'b1; Rd = 64'h100;
        step("br_0x100", 64'h100);
        clearCtrl();
        #2 rst = 1'b0;
        #1;
        check("async_reset_pc", currPC, 64'h0);
        check("async_reset_plus4", pc_plus4, 64'h4);
        #1 rst = 1'b1;
        step("after_reset", 64'h4);

        check("queue_drained", 64'(expQ.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
